// File: rtl/input_dbuf_ctrl_if.sv
// Handshake/bus bundle for the input activation double-buffer controller.
// slave: controller side; master: stream/config/read-side/generator side.
interface input_dbuf_ctrl_if #(
    parameter int CONFIG_WIDTH = 32
) ();
    logic                    cfg_valid;
    logic [CONFIG_WIDTH-1:0] cfg_data;
    logic                    cfg_ready;
    logic                    gen_config_enable;
    logic [CONFIG_WIDTH-1:0] gen_config_data;
    logic                    gen_addr_enable;
    logic                    gen_writing_last_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    bank_wen;
    logic                    wr_bank_sel;
    logic                    rd_block_ready;
    logic                    rd_bank_sel;
    logic                    rd_block_done;
    logic                    layer_done;

    modport slave (
        input  cfg_valid, cfg_data, gen_writing_last_data,
        input  in_valid, rd_block_done,
        output cfg_ready, gen_config_enable, gen_config_data,
        output gen_addr_enable, in_ready, bank_wen, wr_bank_sel,
        output rd_block_ready, rd_bank_sel, layer_done
    );

    modport master (
        output cfg_valid, cfg_data, gen_writing_last_data,
        output in_valid, rd_block_done,
        input  cfg_ready, gen_config_enable, gen_config_data,
        input  gen_addr_enable, in_ready, bank_wen, wr_bank_sel,
        input  rd_block_ready, rd_bank_sel, layer_done
    );
endinterface

// File: rtl/input_dbuf_ctrl.sv
// Input activation ping-pong buffer controller: config load, block writes
// into two banks, hand-off to the read side, layer completion pulse.
// Ports: clk, rst_n (sync, active-low), bus (input_dbuf_ctrl_if.slave).
module input_dbuf_ctrl #(
    parameter int CONFIG_WIDTH    = 32,
    parameter int BLOCK_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input_dbuf_ctrl_if.slave       bus
);
    localparam int BW = BLOCK_CNT_WIDTH;
    localparam logic [BW-1:0] ONE = BW'(1);

    typedef enum logic [1:0] {CFG0, CFG1, RUN} state_e;

    state_e        state_q;
    logic [BW-1:0] num_blocks_q;
    logic [BW-1:0] blk_wr_q;
    logic [BW-1:0] blk_rd_q;
    logic [1:0]    full_q;
    logic          wr_sel_q;
    logic          rd_sel_q;
    logic          layer_done_q;

    logic run;
    logic wr;
    logic close_blk;
    logic release_blk;

    assign run = (state_q == RUN);

    assign bus.cfg_ready = (state_q != RUN);
    assign bus.gen_config_enable = (state_q == CFG0) && bus.cfg_valid;
    assign bus.gen_config_data =
        bus.gen_config_enable ? bus.cfg_data : '0;

    assign bus.in_ready = run && !full_q[wr_sel_q]
                          && (blk_wr_q < num_blocks_q);
    assign wr = bus.in_valid && bus.in_ready;
    assign bus.gen_addr_enable = wr;
    assign bus.bank_wen = wr;
    assign close_blk = wr && bus.gen_writing_last_data;

    assign bus.rd_block_ready = run && full_q[rd_sel_q];
    // A done pulse with no complete block on offer is dropped.
    assign release_blk = bus.rd_block_done && bus.rd_block_ready;

    assign bus.wr_bank_sel = wr_sel_q;
    assign bus.rd_bank_sel = rd_sel_q;
    assign bus.layer_done = layer_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CFG0;
            num_blocks_q <= '0;
            blk_wr_q     <= '0;
            blk_rd_q     <= '0;
            full_q       <= 2'b00;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= 1'b0;
            case (state_q)
                CFG0: begin
                    if (bus.cfg_valid) begin
                        state_q <= CFG1;
                    end
                end
                CFG1: begin
                    if (bus.cfg_valid) begin
                        num_blocks_q <= bus.cfg_data[BW-1:0];
                        blk_wr_q     <= '0;
                        blk_rd_q     <= '0;
                        full_q       <= 2'b00;
                        wr_sel_q     <= 1'b0;
                        rd_sel_q     <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (num_blocks_q == '0) begin
                        state_q      <= CFG0;
                        layer_done_q <= 1'b1;
                    end else begin
                        // Close and release never hit the same bank:
                        // a write needs its bank empty, a release full.
                        if (close_blk) begin
                            full_q[wr_sel_q] <= 1'b1;
                            wr_sel_q         <= ~wr_sel_q;
                            blk_wr_q         <= blk_wr_q + ONE;
                        end
                        if (release_blk) begin
                            full_q[rd_sel_q] <= 1'b0;
                            rd_sel_q         <= ~rd_sel_q;
                            blk_rd_q         <= blk_rd_q + ONE;
                            if (blk_rd_q + ONE == num_blocks_q) begin
                                state_q      <= CFG0;
                                layer_done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= CFG0;
            endcase
        end
    end
endmodule

// File: tb/tb_input_dbuf_ctrl.sv
// Self-checking bench for input_dbuf_ctrl with a behavioural
// write address generator and a block hand-off scoreboard.
module tb_input_dbuf_ctrl;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    input_dbuf_ctrl_if #(.CONFIG_WIDTH(CW)) bus ();

    input_dbuf_ctrl #(
        .CONFIG_WIDTH(CW),
        .BLOCK_CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Write address generator model: wraps after depth addresses.
    logic [CW-1:0] g_depth;
    logic [CW-1:0] g_addr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_depth <= '0;
            g_addr  <= '0;
        end else if (bus.gen_config_enable) begin
            g_depth <= bus.gen_config_data;
            g_addr  <= '0;
        end else if (bus.gen_addr_enable) begin
            g_addr <= (g_addr + 1 == g_depth) ? '0 : g_addr + 1;
        end
    end
    assign bus.gen_writing_last_data = (g_addr + 1 == g_depth);

    typedef struct {
        logic bank;
        int   cyc;
    } blk_ev_t;
    blk_ev_t sb_q[$];

    // {cfg_ready, gen_config_enable, gen_addr_enable, in_ready, bank_wen,
    //  wr_bank_sel, rd_block_ready, rd_bank_sel, layer_done}
    function automatic logic [8:0] outs();
        return {bus.cfg_ready, bus.gen_config_enable, bus.gen_addr_enable,
                bus.in_ready, bus.bank_wen, bus.wr_bank_sel,
                bus.rd_block_ready, bus.rd_bank_sel, bus.layer_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus.in_valid = 1'b0;
        bus.rd_block_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_config(input int depth, input int nb);
        bus.cfg_valid = 1'b1;
        bus.cfg_data = CW'(depth);
        step();
        bus.cfg_data = CW'(nb);
        step();
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (outs() !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", outs(), 9'b1_0000_0000);
        end
        n_tests++;
        if (bus.gen_config_data !== '0) begin
            n_fail++;
            $display("FAIL reset_gcd: got %0h want 0", bus.gen_config_data);
        end
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int beats = 0;
        int closes = 0;
        int done_at = -1;
        int layers = 0;
        bit seen = 0;
        logic prev_rdy = 1'b0;
        logic prev_done = 1'b0;
        blk_ev_t ev;
        do_reset();
        sb_q.delete();
        bus.cfg_valid = 1'b1;
        bus.cfg_data = 32'd4;
        @(negedge clk);
        n_tests++;
        if ({bus.cfg_ready, bus.gen_config_enable} !== 2'b11
            || bus.gen_config_data !== 32'd4) begin
            n_fail++;
            $display("FAIL cfg0_strobe: got rdy/en %b%b data %0d want 11 4",
                     bus.cfg_ready, bus.gen_config_enable, bus.gen_config_data);
        end
        step();
        bus.cfg_data = 32'd3;
        @(negedge clk);
        n_tests++;
        if ({bus.cfg_ready, bus.gen_config_enable} !== 2'b10
            || bus.gen_config_data !== 32'd0) begin
            n_fail++;
            $display("FAIL cfg1_strobe: got rdy/en %b%b data %0d want 10 0",
                     bus.cfg_ready, bus.gen_config_enable, bus.gen_config_data);
        end
        step();
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.rd_block_done = (cyc == done_at);
            @(negedge clk);
            if (cyc == 0) begin
                n_tests++;
                if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_ready: got in_ready %b cfg_ready %b want 1 0",
                             bus.in_ready, bus.cfg_ready);
                end
            end
            if (bus.bank_wen) begin
                n_tests++;
                if (bus.wr_bank_sel !== closes[0]) begin
                    n_fail++;
                    $display("FAIL wr_bank_sel beat %0d: got %b want %b",
                             beats + 1, bus.wr_bank_sel, closes[0]);
                end
                beats++;
                if (bus.gen_writing_last_data) begin
                    ev.bank = closes[0];
                    ev.cyc = cyc + 1;
                    sb_q.push_back(ev);
                    closes++;
                end
            end
            if (bus.rd_block_ready && !(prev_rdy && !prev_done)) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_block_unexpected: got block at cycle %0d want none",
                             cyc);
                end else begin
                    ev = sb_q.pop_front();
                    if (bus.rd_bank_sel !== ev.bank || cyc != ev.cyc) begin
                        n_fail++;
                        $display("FAIL rd_block: got bank %b cycle %0d want bank %b cycle %0d",
                                 bus.rd_bank_sel, cyc, ev.bank, ev.cyc);
                    end
                end
                done_at = cyc + 2;
            end
            prev_rdy = bus.rd_block_ready;
            prev_done = bus.rd_block_done;
            if (bus.layer_done) begin
                layers++;
                seen = 1;
                n_tests++;
                if (bus.cfg_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_cfg_ready: got %b want 1", bus.cfg_ready);
                end
                step();
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.rd_block_done = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL basic_timeout: got no layer_done want one within 80 cycles");
        end
        @(negedge clk);
        if (bus.layer_done) layers++;
        n_tests++;
        if (layers != 1 || beats != 12 || closes != 3 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_totals: got layers %0d beats %0d blocks %0d left %0d want 1 12 3 0",
                     layers, beats, closes, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        do_reset();
        do_config(2, 4);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bank_wen) beats++;
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (beats != 4) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d want 4", beats);
        end
        n_tests++;
        if ({bus.in_ready, bus.rd_block_ready, bus.wr_bank_sel, bus.rd_bank_sel}
            !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_stall: got rdy/rbr/wsel/rsel %b%b%b%b want 0100",
                     bus.in_ready, bus.rd_block_ready, bus.wr_bank_sel, bus.rd_bank_sel);
        end
        bus.rd_block_done = 1'b1;
        step();
        bus.rd_block_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.wr_bank_sel, bus.rd_bank_sel, bus.rd_block_ready}
            !== 4'b1011) begin
            n_fail++;
            $display("FAIL bp_release: got rdy/wsel/rsel/rbr %b%b%b%b want 1011",
                     bus.in_ready, bus.wr_bank_sel, bus.rd_bank_sel, bus.rd_block_ready);
        end
        step();
    endtask

    task automatic test_coincide();
        do_reset();
        do_config(2, 4);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rd_block_done = (i == 3);
            @(negedge clk);
            if (i == 3) begin
                n_tests++;
                if ({bus.bank_wen, bus.gen_writing_last_data, bus.wr_bank_sel,
                     bus.rd_block_ready, bus.rd_bank_sel} !== 5'b11110) begin
                    n_fail++;
                    $display("FAIL coincide_pre: got %b%b%b%b%b want 11110",
                             bus.bank_wen, bus.gen_writing_last_data, bus.wr_bank_sel,
                             bus.rd_block_ready, bus.rd_bank_sel);
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.rd_block_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.wr_bank_sel, bus.rd_bank_sel, bus.rd_block_ready}
            !== 4'b1011) begin
            n_fail++;
            $display("FAIL coincide_post: got rdy/wsel/rsel/rbr %b%b%b%b want 1011",
                     bus.in_ready, bus.wr_bank_sel, bus.rd_bank_sel, bus.rd_block_ready);
        end
        step();
    endtask

    task automatic test_ignore_done();
        do_reset();
        do_config(2, 1);
        bus.rd_block_done = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.rd_block_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_ready: got %b want 0", bus.rd_block_ready);
        end
        step();
        bus.rd_block_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.layer_done, bus.rd_bank_sel, bus.in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL ign_state: got ld/rsel/rdy %b%b%b want 001",
                     bus.layer_done, bus.rd_bank_sel, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        bus.rd_block_done = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.rd_block_ready, bus.rd_bank_sel} !== 2'b10) begin
            n_fail++;
            $display("FAIL ign_block: got rbr/rsel %b%b want 10",
                     bus.rd_block_ready, bus.rd_bank_sel);
        end
        step();
        bus.rd_block_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.layer_done, bus.cfg_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ign_layer_done: got ld/cfg_ready %b%b want 11",
                     bus.layer_done, bus.cfg_ready);
        end
        step();
    endtask

    task automatic test_zero_blocks();
        do_reset();
        do_config(3, 0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.cfg_ready, bus.layer_done, bus.bank_wen} !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_run: got rdy/cfg/ld/wen %b%b%b%b want 0000",
                     bus.in_ready, bus.cfg_ready, bus.layer_done, bus.bank_wen);
        end
        step();
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.cfg_ready, bus.layer_done} !== 3'b011) begin
            n_fail++;
            $display("FAIL zero_done: got rdy/cfg/ld %b%b%b want 011",
                     bus.in_ready, bus.cfg_ready, bus.layer_done);
        end
        step();
        @(negedge clk);
        n_tests++;
        if ({bus.layer_done, bus.in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_after: got ld/rdy %b%b want 00",
                     bus.layer_done, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [2:0] want;
        do_reset();
        do_config(4, 2);
        bus.in_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        n_tests++;
        if (outs() !== 9'b1_0000_0000 || bus.gen_config_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs: got %b gcd %0h want 100000000 gcd 0",
                     outs(), bus.gen_config_data);
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        do_config(4, 1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            want = {1'b1, 1'b0, (i == 3)};
            n_tests++;
            if ({bus.bank_wen, bus.wr_bank_sel, bus.gen_writing_last_data} !== want) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: got wen/wsel/last %b%b%b want %b",
                         i, bus.bank_wen, bus.wr_bank_sel,
                         bus.gen_writing_last_data, want);
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.rd_block_done = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.rd_block_ready, bus.rd_bank_sel, bus.in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_block: got rbr/rsel/rdy %b%b%b want 100",
                     bus.rd_block_ready, bus.rd_bank_sel, bus.in_ready);
        end
        step();
        bus.rd_block_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.layer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_layer_done: got %b want 1", bus.layer_done);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_basic();
        test_backpressure();
        test_coincide();
        test_ignore_done();
        test_zero_blocks();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
